// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller: data-memory wait handling with timeout,
// load-use interlock and taken-branch flush, plus a saturating stall counter.
module pipe_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_MemRead,
  input  logic [4:0]       ex_RegisterRd,
  input  logic             ex_branch_taken,
  input  logic             mem_MemRead,
  input  logic             mem_MemWrite,
  input  logic             dmem_ack,
  output logic             dmem_req,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_bubble,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  // waitCnt counts cycles already spent waiting, so the IDLE stall cycle is
  // the first one and the access is abandoned after TIMEOUT cycles in total.
  localparam logic [7:0] WAIT_LIM = 8'(TIMEOUT - 1);

  typedef enum logic {IDLE, BUSY} stateT;

  stateT      state;
  logic [7:0] waitCnt;
  logic       memOp;
  logic       timeOut;
  logic       memStall;
  logic       luStall;

  // Hazard detection terms
  assign memOp    = mem_MemRead | mem_MemWrite;
  assign timeOut  = (state == BUSY) & (waitCnt >= WAIT_LIM) & !dmem_ack;
  assign memStall = memOp & !dmem_ack & !timeOut;
  assign luStall  = ex_MemRead & (ex_RegisterRd != 5'd0) &
                    ((ex_RegisterRd == id_rs) |
                     (id_uses_rt & (ex_RegisterRd == id_rt)));

  // Prioritised stage control: memory stall, then branch flush, then load-use
  always_comb begin
    dmem_req     = 1'b0;
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    idex_en      = 1'b1;
    exmem_en     = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    memwb_bubble = 1'b0;
    if (!rst) begin
      dmem_req = memOp;
      if (memStall) begin
        pc_en        = 1'b0;
        ifid_en      = 1'b0;
        idex_en      = 1'b0;
        exmem_en     = 1'b0;
        memwb_bubble = 1'b1;
      end else begin
        if (ex_branch_taken) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (luStall) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
        end
        if (timeOut) begin
          memwb_bubble = 1'b1;
        end
      end
    end
  end

  // Memory-wait FSM, wait counter, sticky error and stall statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      waitCnt   <= 8'd0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (memOp && !dmem_ack) begin
            state   <= BUSY;
            waitCnt <= 8'd1;
          end else begin
            waitCnt <= 8'd0;
          end
        end
        BUSY: begin
          if (dmem_ack || timeOut) begin
            state   <= IDLE;
            waitCnt <= 8'd0;
          end else begin
            waitCnt <= waitCnt + 8'd1;
          end
        end
        default: begin
          state   <= IDLE;
          waitCnt <= 8'd0;
        end
      endcase
      if (timeOut) begin
        mem_err <= 1'b1;
      end
      if ((memStall || luStall) && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs, id_rt, ex_RegisterRd;
  logic        id_uses_rt, ex_MemRead, ex_branch_taken;
  logic        mem_MemRead, mem_MemWrite, dmem_ack;

  logic        dmem_req, pc_en, ifid_en, idex_en, exmem_en;
  logic        ifid_flush, idex_flush, memwb_bubble, mem_err;
  logic [15:0] stall_cnt;

  logic        dmem_req2, pc_en2, ifid_en2, idex_en2, exmem_en2;
  logic        ifid_flush2, idex_flush2, memwb_bubble2, mem_err2;
  logic [1:0]  stall_cnt2;

  int nChecks = 0;
  int nPass   = 0;

  // {dmem_req, pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_bubble}
  localparam logic [7:0] C_NORM   = 8'b0_1111_00_0;
  localparam logic [7:0] C_NORMRQ = 8'b1_1111_00_0;
  localparam logic [7:0] C_MSTALL = 8'b1_0000_00_1;
  localparam logic [7:0] C_LU     = 8'b0_0011_01_0;
  localparam logic [7:0] C_BR     = 8'b0_1111_11_0;
  localparam logic [7:0] C_BRRQ   = 8'b1_1111_11_0;
  localparam logic [7:0] C_TMO    = 8'b1_1111_00_1;

  logic [7:0] ctl;
  assign ctl = {dmem_req, pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_bubble};

  always #5 clk = ~clk;

  pipe_ctrl #(.TIMEOUT(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_MemRead(ex_MemRead), .ex_RegisterRd(ex_RegisterRd), .ex_branch_taken(ex_branch_taken),
    .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite), .dmem_ack(dmem_ack),
    .dmem_req(dmem_req), .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .memwb_bubble(memwb_bubble), .mem_err(mem_err), .stall_cnt(stall_cnt)
  );

  // Narrow-counter instance for saturation
  pipe_ctrl #(.TIMEOUT(2), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_MemRead(ex_MemRead), .ex_RegisterRd(ex_RegisterRd), .ex_branch_taken(ex_branch_taken),
    .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite), .dmem_ack(dmem_ack),
    .dmem_req(dmem_req2), .pc_en(pc_en2), .ifid_en(ifid_en2), .idex_en(idex_en2),
    .exmem_en(exmem_en2), .ifid_flush(ifid_flush2), .idex_flush(idex_flush2),
    .memwb_bubble(memwb_bubble2), .mem_err(mem_err2), .stall_cnt(stall_cnt2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic clrIn();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
    ex_MemRead = 1'b0; ex_RegisterRd = 5'd0; ex_branch_taken = 1'b0;
    mem_MemRead = 1'b0; mem_MemWrite = 1'b0; dmem_ack = 1'b0;
  endtask

  // Advance to the next negedge; combinational checks follow a #1 settle
  task automatic nextCyc();
    @(negedge clk);
  endtask

  initial begin
    // Reset with hazardous inputs applied: outputs must be benign
    clrIn();
    rst = 1'b1;
    mem_MemRead = 1'b1; ex_MemRead = 1'b1; ex_RegisterRd = 5'd5; id_rs = 5'd5;
    ex_branch_taken = 1'b1;
    nextCyc(); #1;
    check("rst_ctl", 32'(ctl), 32'(C_NORM));
    nextCyc();
    check("rst_cnt", 32'(stall_cnt), 32'd0);
    check("rst_err", 32'(mem_err), 32'd0);

    // Load-use on rs
    rst = 1'b0; clrIn();
    ex_MemRead = 1'b1; ex_RegisterRd = 5'd5; id_rs = 5'd5; #1;
    check("lu_rs_ctl", 32'(ctl), 32'(C_LU));
    nextCyc();
    check("lu_rs_cnt", 32'(stall_cnt), 32'd1);
    id_rs = 5'd6; #1;
    check("lu_clear_ctl", 32'(ctl), 32'(C_NORM));
    nextCyc();
    check("lu_clear_cnt", 32'(stall_cnt), 32'd1);

    // Load-use on rt, then rt not used
    ex_RegisterRd = 5'd7; id_rs = 5'd3; id_rt = 5'd7; id_uses_rt = 1'b1; #1;
    check("lu_rt_ctl", 32'(ctl), 32'(C_LU));
    nextCyc();
    id_uses_rt = 1'b0; #1;
    check("lu_rt_unused_ctl", 32'(ctl), 32'(C_NORM));
    nextCyc();
    check("lu_rt_cnt", 32'(stall_cnt), 32'd2);

    // Load into r0 never interlocks
    ex_RegisterRd = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b1; #1;
    check("lu_r0_ctl", 32'(ctl), 32'(C_NORM));
    nextCyc();
    check("lu_r0_cnt", 32'(stall_cnt), 32'd2);

    // Plain taken branch
    clrIn(); ex_branch_taken = 1'b1; #1;
    check("br_ctl", 32'(ctl), 32'(C_BR));
    nextCyc();

    // Load acked after 3 wait cycles
    clrIn(); mem_MemRead = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check($sformatf("mw3_stall%0d", i), 32'(ctl), 32'(C_MSTALL));
      nextCyc();
    end
    dmem_ack = 1'b1; #1;
    check("mw3_ack_ctl", 32'(ctl), 32'(C_NORMRQ));
    nextCyc();
    check("mw3_cnt", 32'(stall_cnt), 32'd5);

    // Zero-wait store: no stall
    clrIn(); mem_MemWrite = 1'b1; dmem_ack = 1'b1; #1;
    check("zw_ctl", 32'(ctl), 32'(C_NORMRQ));
    nextCyc();
    check("zw_cnt", 32'(stall_cnt), 32'd5);

    // Branch during memory stall is deferred to the ack cycle
    clrIn(); mem_MemRead = 1'b1; ex_branch_taken = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1 check($sformatf("brms_stall%0d", i), 32'(ctl), 32'(C_MSTALL));
      nextCyc();
    end
    dmem_ack = 1'b1; #1;
    check("brms_ack_ctl", 32'(ctl), 32'(C_BRRQ));
    nextCyc();
    check("brms_cnt", 32'(stall_cnt), 32'd7);

    // Timeout after 4 cycles with TIMEOUT=4
    clrIn(); mem_MemRead = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check($sformatf("tmo_stall%0d", i), 32'(ctl), 32'(C_MSTALL));
      nextCyc();
    end
    #1 check("tmo_ctl", 32'(ctl), 32'(C_TMO));
    check("tmo_err_before", 32'(mem_err), 32'd0);
    nextCyc();
    check("tmo_err_set", 32'(mem_err), 32'd1);
    check("tmo_cnt", 32'(stall_cnt), 32'd10);
    clrIn(); #1;
    check("post_tmo_ctl", 32'(ctl), 32'(C_NORM));
    nextCyc();
    check("err_sticky", 32'(mem_err), 32'd1);

    // Branch overrides load-use
    ex_branch_taken = 1'b1; ex_MemRead = 1'b1; ex_RegisterRd = 5'd5; id_rs = 5'd5; #1;
    check("br_lu_ctl", 32'(ctl), 32'(C_BR));
    nextCyc();

    // Reset while BUSY after 2 wait cycles
    clrIn(); mem_MemRead = 1'b1;
    nextCyc(); nextCyc();
    rst = 1'b1; #1;
    check("rstbusy_ctl", 32'(ctl), 32'(C_NORM));
    nextCyc();
    check("rstbusy_err", 32'(mem_err), 32'd0);
    check("rstbusy_cnt", 32'(stall_cnt), 32'd0);

    // Fresh access after reset starts from IDLE with a cleared wait count
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 check($sformatf("rst_idle_stall%0d", i), 32'(ctl), 32'(C_MSTALL));
      nextCyc();
    end
    dmem_ack = 1'b1; #1;
    check("rst_idle_ack", 32'(ctl), 32'(C_NORMRQ));
    nextCyc();
    check("rst_idle_err", 32'(mem_err), 32'd0);

    // Five load-use cycles: wide counter counts, narrow counter saturates
    clrIn(); ex_MemRead = 1'b1; ex_RegisterRd = 5'd9; id_rt = 5'd9; id_uses_rt = 1'b1;
    for (int i = 0; i < 5; i++) nextCyc();
    check("sat_wide_cnt", 32'(stall_cnt), 32'd8);
    check("sat_narrow_cnt", 32'(stall_cnt2), 32'd3);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter TIMEOUT, 255, max wait cycles for dmem_ack before an access is abandoned (1..255).
REQ-002 Parameter CNT_W, 16, width of the stall statistics counter.
REQ-003 clk  in  1  clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 id_rs, id_rt  in  5 each  source registers of the instruction in ID.
REQ-006 id_uses_rt  in  1  ID instruction reads rt.
REQ-007 ex_MemRead  in  1  EX instruction is a load.
REQ-008 ex_RegisterRd  in  5  EX instruction destination register.
REQ-009 ex_branch_taken  in  1  branch/jump resolved taken in EX.
REQ-010 mem_MemRead, mem_MemWrite  in  1 each  control bits held in the EX/MEM register.
REQ-011 dmem_ack  in  1  data memory completes the current access this cycle.
REQ-012 dmem_req  out  1  data memory access request.
REQ-013 pc_en, ifid_en, idex_en, exmem_en  out  1 each  stage register load enables.
REQ-014 ifid_flush, idex_flush  out  1 each  clear IF/ID or ID/EX to a bubble next edge.
REQ-015 memwb_bubble  out  1  force MEM/WB RegWrite/MemtoReg to 0 next edge.
REQ-016 mem_err  out  1  sticky timeout flag.
REQ-017 stall_cnt  out  CNT_W  saturating count of cycles with any stall asserted.

Function
REQ-018 memop = mem_MemRead | mem_MemWrite; dmem_req SHALL equal memop (combinational) whenever rst=0.
REQ-019 FSM states IDLE, BUSY; IDLE->BUSY when memop & !dmem_ack; BUSY->IDLE on dmem_ack or timeout; otherwise hold.
REQ-020 wait_cnt (8 bit) SHALL clear in IDLE and increment each BUSY cycle; timeout = BUSY & wait_cnt == TIMEOUT-1 & !dmem_ack.
REQ-021 mem_stall = memop & !dmem_ack & !timeout; a zero-wait ack (ack in first cycle) SHALL cause no stall.
REQ-022 On timeout, mem_err SHALL set (sticky until rst), the access SHALL complete as if acked, and memwb_bubble SHALL be 1 that cycle.
REQ-023 lu_stall = ex_MemRead & ex_RegisterRd != 0 & (ex_RegisterRd == id_rs | (id_uses_rt & ex_RegisterRd == id_rt)).
REQ-024 Priority 1, mem_stall: pc_en=ifid_en=idex_en=exmem_en=0, both flushes 0, memwb_bubble=1.
REQ-025 Priority 2, ex_branch_taken: all enables 1, ifid_flush=1, idex_flush=1 (overrides lu_stall).
REQ-026 Priority 3, lu_stall: pc_en=0, ifid_en=0, idex_en=1, idex_flush=1, exmem_en=1; exactly one bubble per load-use pair.
REQ-027 Otherwise all enables 1, flushes 0, memwb_bubble 0.
REQ-028 mem_stall concurrent with branch or load-use SHALL defer them; they re-evaluate on the first non-stalled cycle.
REQ-029 stall_cnt SHALL increment on any cycle with mem_stall | lu_stall asserted and saturate at 2^CNT_W-1.
REQ-030 All outputs except stall_cnt, mem_err SHALL be combinational from inputs and FSM state.

Reset
REQ-031 On rst: FSM=IDLE, wait_cnt=0, mem_err=0, stall_cnt=0.
REQ-032 While rst=1: dmem_req=0, all enables 1, flushes 0, memwb_bubble 0, regardless of inputs.
REQ-033 rst asserted in BUSY SHALL abandon the access with no mem_err; first cycle after reset is IDLE.

Verification
REQ-034 Load r5 in EX, ID reads rs=5 -> one cycle pc_en=0, ifid_en=0, idex_flush=1; stall_cnt=1.
REQ-035 Load rd=0 in EX, ID rs=0 -> no stall, all enables 1.
REQ-036 mem_MemRead=1, dmem_ack after 3 cycles -> dmem_req high 4 cycles, enables 0 for 3 cycles, 1 on ack cycle; stall_cnt=3.
REQ-037 memop held, no ack, TIMEOUT=4 -> stall 3 cycles, 4th cycle mem_err=1, memwb_bubble=1, enables 1.
REQ-038 ex_branch_taken=1 during mem_stall -> no flush until ack cycle, then ifid_flush=idex_flush=1.
REQ-039 rst=1 in BUSY after 2 wait cycles -> dmem_req=0 immediately, mem_err=0, stall_cnt=0 next cycle.
